// File: rtl/alu_dispatch_pkg.sv
// Shared ALU select codes, MIPS opcode/funct values and the decoded-operation record
// used by the alu_dispatch decoder and its two-entry buffer.
package alu_dispatch_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1011
    } alu_ctrl_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        alu_ctrl_e   ctrl;
        logic [31:0] first;
        logic [31:0] second;
        logic [4:0]  shamt;
        logic        illegal;
    } alu_op_t;

endpackage

// File: rtl/alu_dispatch_decode.sv
// Combinational MIPS instruction -> ALU operation decode.
// Define ALU_DISPATCH_LUI_EN to decode lui as a 16-bit left shift of the immediate.
module alu_dispatch_decode
    import alu_dispatch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output alu_op_t     op
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        unused_reg_fields;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'h0000, instr[15:0]};
    // Register specifiers arrive already resolved through rs_data/rt_data.
    assign unused_reg_fields = ^instr[25:16];

    always_comb begin
        // Default is the illegal encoding: add of the two register operands.
        op = '{ctrl: ALU_ADD, first: rs_data, second: rt_data, shamt: 5'd0, illegal: 1'b1};
        case (opcode)
            OP_RTYPE: begin
                op.illegal = 1'b0;
                case (funct)
                    FN_AND:           op.ctrl = ALU_AND;
                    FN_OR:            op.ctrl = ALU_OR;
                    FN_ADD, FN_ADDU:  op.ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU:  op.ctrl = ALU_SUB;
                    FN_SLT:           op.ctrl = ALU_SLT;
                    FN_SLTU:          op.ctrl = ALU_SLTU;
                    FN_SLL: begin
                        op.ctrl  = ALU_SLL;
                        op.shamt = instr[10:6];
                    end
                    FN_SRL: begin
                        op.ctrl  = ALU_SRL;
                        op.shamt = instr[10:6];
                    end
                    default:          op.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                op.second  = imm_sext;
                op.illegal = 1'b0;
            end
            OP_SLTI: begin
                op.ctrl    = ALU_SLT;
                op.second  = imm_sext;
                op.illegal = 1'b0;
            end
            OP_SLTIU: begin
                op.ctrl    = ALU_SLTU;
                op.second  = imm_sext;
                op.illegal = 1'b0;
            end
            OP_ANDI: begin
                op.ctrl    = ALU_AND;
                op.second  = imm_zext;
                op.illegal = 1'b0;
            end
            OP_ORI: begin
                op.ctrl    = ALU_OR;
                op.second  = imm_zext;
                op.illegal = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                op.ctrl    = ALU_SUB;
                op.illegal = 1'b0;
            end
            OP_LUI: begin
`ifdef ALU_DISPATCH_LUI_EN
                op.ctrl    = ALU_SLL;
                op.first   = 32'h0;
                op.second  = imm_zext;
                op.shamt   = 5'd16;
                op.illegal = 1'b0;
`else
                op.illegal = 1'b1;
`endif
            end
            default: op.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_dispatch.sv
// Two-entry (output + skid) buffer between decode and execute, plus a saturating
// illegal-instruction counter. Build option ALU_DISPATCH_LUI_EN enables lui decode.
module alu_dispatch
    import alu_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] first_op,
    output logic [31:0] second_op,
    output logic [4:0]  shamt,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    alu_op_t    dec_op;
    alu_op_t    out_q, out_d;
    alu_op_t    skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic       accept;
    logic       consume;

    alu_dispatch_decode u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .op      (dec_op)
    );

    // in_ready depends only on a register, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && !skid_valid_q && !flush;
    assign consume  = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = dec_op;
                end
            end
        end else if (accept) begin
            skid_d       = dec_op;
            skid_valid_d = 1'b1;
        end
        if (accept && dec_op.illegal && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= 8'h00;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_ctrl    = out_q.ctrl;
    assign first_op    = out_q.first;
    assign second_op   = out_q.second;
    assign shamt       = out_q.shamt;
    assign illegal     = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized and directed checks of alu_dispatch against a queue-based reference model.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] first_op;
    logic [31:0] second_op;
    logic [4:0]  shamt;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    alu_dispatch dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .first_op    (first_op),
        .second_op   (second_op),
        .shamt       (shamt),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   m_cnt;
    int   checks;
    int   failures;

    logic [5:0] op_tab [12] = '{6'h08, 6'h09, 6'h23, 6'h2B, 6'h0A, 6'h0B,
                                6'h0C, 6'h0D, 6'h04, 6'h05, 6'h0F, 6'h3F};
    logic [5:0] fn_tab [11] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h3F};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Straight from the opcode/funct table: what the execute stage should see.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] sx;
        logic [31:0] zx;
        opc = w[31:26];
        fn  = w[5:0];
        sx  = {{16{w[15]}}, w[15:0]};
        zx  = {16'h0000, w[15:0]};
        e   = '{4'd2, rs, rt, 5'd0, 1'b0};
        if (opc == 6'h00) begin
            case (fn)
                6'h24:        e.c = 4'd0;
                6'h25:        e.c = 4'd1;
                6'h20, 6'h21: e.c = 4'd2;
                6'h22, 6'h23: e.c = 4'd6;
                6'h2A:        e.c = 4'd7;
                6'h2B:        e.c = 4'd11;
                6'h00: begin e.c = 4'd3; e.s = w[10:6]; end
                6'h02: begin e.c = 4'd4; e.s = w[10:6]; end
                default:      e.ill = 1'b1;
            endcase
        end else begin
            case (opc)
                6'h08, 6'h09, 6'h23, 6'h2B: e.b = sx;
                6'h0A: begin e.c = 4'd7;  e.b = sx; end
                6'h0B: begin e.c = 4'd11; e.b = sx; end
                6'h0C: begin e.c = 4'd0;  e.b = zx; end
                6'h0D: begin e.c = 4'd1;  e.b = zx; end
                6'h04, 6'h05: e.c = 4'd6;
`ifdef ALU_DISPATCH_LUI_EN
                6'h0F: begin e.c = 4'd3; e.a = 32'h0; e.b = zx; e.s = 5'd16; end
`endif
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            w[31:26] = 6'h00;
            w[5:0]   = fn_tab[$urandom_range(0, 10)];
        end else begin
            w[31:26] = op_tab[$urandom_range(0, 11)];
        end
        return w;
    endfunction

    task automatic compare_model();
        check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check_eq("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check_eq("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
        if (q.size() > 0) begin
            check_eq("alu_ctrl", 32'(alu_ctrl), 32'(q[0].c));
            check_eq("first_op", first_op, q[0].a);
            check_eq("second_op", second_op, q[0].b);
            check_eq("shamt", 32'(shamt), 32'(q[0].s));
            check_eq("illegal", 32'(illegal), 32'(q[0].ill));
        end
    endtask

    // One clock: check at negedge, drive, then advance the model at posedge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] rs,
                         input logic [31:0] rt, input logic ordy, input logic fl);
        exp_t e;
        logic acc;
        logic cons;
        @(negedge clk);
        compare_model();
        in_valid  = v;
        instr     = w;
        rs_data   = rs;
        rt_data   = rt;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        e    = ref_decode(w, rs, rt);
        acc  = v && (q.size() < 2) && !fl;
        cons = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (cons) begin
                $display("xfer ctrl=%h a=%h b=%h sh=%0d ill=%0b", q[0].c, q[0].a, q[0].b, q[0].s, q[0].ill);
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        if (acc && e.ill && m_cnt < 255) m_cnt++;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        instr     = 32'h0;
        rs_data   = 32'h0;
        rt_data   = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    logic [31:0] w_ill;
    int          cnt_before;

    initial begin
        checks   = 0;
        failures = 0;
        m_cnt    = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check_eq("rst_first_op", first_op, 32'd0);
        check_eq("rst_second_op", second_op, 32'd0);
        check_eq("rst_shamt", 32'(shamt), 32'd0);
        check_eq("rst_illegal", 32'(illegal), 32'd0);
        check_eq("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);

        // add $3,$1,$2
        cycle(1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0);
        #1;
        check_eq("add_valid", 32'(out_valid), 32'd1);
        check_eq("add_ctrl", 32'(alu_ctrl), 32'h2);
        check_eq("add_a", first_op, 32'd5);
        check_eq("add_b", second_op, 32'd7);
        check_eq("add_sh", 32'(shamt), 32'd0);

        // sll $2,$1,4
        cycle(1'b1, 32'h00011100, 32'd0, 32'h3, 1'b1, 1'b0);
        #1;
        check_eq("sll_ctrl", 32'(alu_ctrl), 32'h3);
        check_eq("sll_b", second_op, 32'h3);
        check_eq("sll_sh", 32'(shamt), 32'd4);

        // addi / andi immediate extension
        cycle(1'b1, 32'h2022FFFF, 32'd1, 32'd2, 1'b1, 1'b0);
        #1;
        check_eq("addi_b", second_op, 32'hFFFFFFFF);
        cycle(1'b1, 32'h3022FFFF, 32'd1, 32'd2, 1'b1, 1'b0);
        #1;
        check_eq("andi_b", second_op, 32'h0000FFFF);

        // Back-pressure: two held, third refused until release.
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h00221820, 32'h11, 32'h1, 1'b0, 1'b0);
        #1;
        check_eq("bp_ready1", 32'(in_ready), 32'd1);
        cycle(1'b1, 32'h00221822, 32'h22, 32'h2, 1'b0, 1'b0);
        #1;
        check_eq("bp_ready2", 32'(in_ready), 32'd0);
        cycle(1'b1, 32'h00221824, 32'h33, 32'h3, 1'b0, 1'b0);
        cycle(1'b1, 32'h00221824, 32'h33, 32'h3, 1'b1, 1'b0);
        #1;
        check_eq("bp_second_out", first_op, 32'h22);
        cycle(1'b1, 32'h00221824, 32'h33, 32'h3, 1'b1, 1'b0);
        #1;
        check_eq("bp_third_out", first_op, 32'h33);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // lui
        cnt_before = m_cnt;
        cycle(1'b1, 32'h3C031234, 32'd9, 32'd9, 1'b1, 1'b0);
        #1;
`ifdef ALU_DISPATCH_LUI_EN
        check_eq("lui_ctrl", 32'(alu_ctrl), 32'h3);
        check_eq("lui_b", second_op, 32'h1234);
        check_eq("lui_sh", 32'(shamt), 32'd16);
        check_eq("lui_a", first_op, 32'h0);
`else
        check_eq("lui_illegal", 32'(illegal), 32'd1);
        check_eq("lui_cnt", 32'(illegal_cnt), 32'(cnt_before + 1));
`endif

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom,
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 24) == 0));
        end

        // Reset while both entries are held.
        cycle(1'b1, 32'h00221820, 32'h1, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'h00221820, 32'h2, 32'h2, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_cnt", 32'(illegal_cnt), 32'd0);
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;

        // Counter saturation, then flush with both entries full.
        for (int i = 0; i < 256; i++) begin
            w_ill = $urandom;
            w_ill[31:26] = 6'h3F;
            cycle(1'b1, w_ill, $urandom, $urandom, 1'b1, 1'b0);
        end
        #1;
        check_eq("sat_cnt", 32'(illegal_cnt), 32'd255);
        cycle(1'b1, w_ill, 32'h5, 32'h5, 1'b0, 1'b0);
        #1;
        check_eq("full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, w_ill, 32'h6, 32'h6, 1'b0, 1'b1);
        #1;
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        check_eq("flush_cnt", 32'(illegal_cnt), 32'd255);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  decode-side instruction offered.
REQ-004 in_ready  output  1  block can accept an instruction this cycle.
REQ-005 instr  input  32  MIPS instruction word.
REQ-006 rs_data  input  32  register-file value for rs.
REQ-007 rt_data  input  32  register-file value for rt.
REQ-008 flush  input  1  discard all held instructions.
REQ-009 out_valid  output  1  ALU operation presented.
REQ-010 out_ready  input  1  execute stage consumes the operation.
REQ-011 alu_ctrl  output  4  ALU select code: and 0000, or 0001, add 0010, sll 0011, srl 0100, sub 0110, slt 0111, sltu 1011.
REQ-012 first_op  output  32  ALU first operand.
REQ-013 second_op  output  32  ALU second operand.
REQ-014 shamt  output  5  shift amount.
REQ-015 illegal  output  1  presented operation came from an undecodable instruction.
REQ-016 illegal_cnt  output  8  saturating count of illegal instructions accepted.

Function
REQ-017 SHALL decode R-type (opcode 0x00) by funct: 0x24 and; 0x25 or; 0x20/0x21 add; 0x22/0x23 sub; 0x2A slt; 0x2B sltu; 0x00 sll; 0x02 srl; first_op=rs_data, second_op=rt_data, shamt=instr[10:6].
REQ-018 SHALL decode I-type: addi 0x08, addiu 0x09, lw 0x23, sw 0x2B -> add, slti 0x0A -> slt, sltiu 0x0B -> sltu, all with sign-extended imm; andi 0x0C -> and, ori 0x0D -> or with zero-extended imm; first_op=rs_data.
REQ-019 SHALL decode beq 0x04 / bne 0x05 as sub with second_op=rt_data.
REQ-020 SHALL drive shamt=0 for every non-shift operation.
REQ-021 Any other opcode/funct SHALL produce alu_ctrl=0010, first_op=rs_data, second_op=rt_data, shamt=0, illegal=1.
REQ-022 Storage: one output register plus one skid register (2 entries), strict FIFO order.
REQ-023 in_ready SHALL equal NOT skid_valid, registered (no combinational path from out_ready).
REQ-024 Accept on in_valid&&in_ready; consume on out_valid&&out_ready.
REQ-025 Latency: accepted instruction appears at outputs next cycle when output register empty or consumed same cycle.
REQ-026 Output empty and skid full impossible; accept into skid only when output held and not consumed.
REQ-027 Simultaneous accept and consume with skid full SHALL move skid to output; new word not accepted (in_ready=0).
REQ-028 Outputs SHALL stay stable while out_valid&&!out_ready.
REQ-029 flush SHALL clear both entries at next edge; instruction offered during flush discarded; illegal_cnt unaffected by flushed entries already counted.
REQ-030 illegal_cnt SHALL increment on each accepted illegal instruction, saturating at 255.

Reset
REQ-031 On reset: out_valid=0, skid empty, in_ready=1, alu_ctrl=0000, first_op=0, second_op=0, shamt=0, illegal=0, illegal_cnt=0.
REQ-032 Reset mid-transfer SHALL drop all held instructions immediately.

Configuration
REQ-033 Macro ALU_DISPATCH_LUI_EN defined: lui (opcode 0x0F) decodes to sll, second_op=zero-extended imm, shamt=16, first_op=0.
REQ-034 Macro undefined: lui treated as illegal per REQ-021.

Structure
REQ-035 Package alu_dispatch_pkg SHALL hold ALU code constants, opcode and funct constants, and the decoded-operation struct typedef.
REQ-036 Combinational decode SHALL live in sub-module alu_dispatch_decode; alu_dispatch holds only buffering and counter.

Verification
REQ-037 add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, ops 5/7, shamt=0.
REQ-038 sll $2,$1,4 (0x00011100), rt=0x3 -> alu_ctrl=0011, second_op=3, shamt=4.
REQ-039 addi imm=0xFFFF, andi imm=0xFFFF -> second_op 0xFFFFFFFF then 0x0000FFFF.
REQ-040 out_ready=0, three back-to-back instructions -> two held, in_ready=0 after second; release -> emerge in order, third accepted.
REQ-041 lui imm=0x1234 -> with macro alu_ctrl=0011, second_op=0x1234, shamt=16; without macro illegal=1, illegal_cnt+1.
REQ-042 256 illegal words, then flush with both entries full -> illegal_cnt=255, out_valid=0, in_ready=1 next cycle.
